packet_egress_executor: RTL and testbench

Consumes the byte stream, start-of-packet pulse and per-packet action word emitted by the upper packet FIFO, and executes that action at egress. Each packet is dropped, forwarded unchanged, or forwarded with one byte rewritten, and is tagged with an egress port. Forwarded bytes go to the TX MAC through a single registered valid/ready output stage. Forwarded and dropped packets are counted.

---
 rtl/packet_egress_executor.sv | 130 +++++++++++++
 tb/tb_packet_egress_executor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_egress_executor.sv
// Executes the per-packet egress action (drop / forward / forward with one byte rewritten) and tags the egress port.
// A byte accepted at cycle K appears on tx_* at K+1; in_ready drops only while the output register is full and stalled.
module packet_egress_executor #(
  parameter int ACTION_W = 64,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_sop,
  input  logic [ACTION_W-1:0] in_action,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_last,
  output logic [1:0]          tx_port,
  input  logic                tx_ready,
  output logic [CNT_W-1:0]    pkt_fwd_cnt,
  output logic [CNT_W-1:0]    pkt_drop_cnt,
  output logic                sop_err
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  typedef struct packed {
    logic [7:0] rewrite_val;
    logic [7:0] rewrite_off;
    logic [3:0] rsvd;
    logic [1:0] port;
    logic       rewrite_en;
    logic       drop;
  } action_t;

  action_t     act;
  state_t      state;
  logic        rw_en;
  logic [7:0]  rw_off;
  logic [7:0]  rw_val;
  logic [10:0] idx;
  logic        accept;
  logic        rw_hit;

  assign act = action_t'(in_action[23:0]);

  if (ACTION_W > 24) begin : g_rsvd
    logic unused_rsvd;
    assign unused_rsvd = ^{in_action[ACTION_W-1:24], act.rsvd};
  end else begin : g_no_rsvd
    logic unused_rsvd;
    assign unused_rsvd = ^act.rsvd;
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      FWD:     in_ready = !tx_valid || tx_ready;
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  // Offset is zero-extended, so bytes beyond 255 can never be rewritten.
  assign rw_hit = rw_en && (idx == {3'b000, rw_off});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rw_en        <= 1'b0;
      rw_off       <= 8'h00;
      rw_val       <= 8'h00;
      idx          <= 11'd0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      tx_last      <= 1'b0;
      tx_port      <= 2'b00;
      pkt_fwd_cnt  <= '0;
      pkt_drop_cnt <= '0;
      sop_err      <= 1'b0;
    end else begin
      if (tx_valid && tx_ready)
        tx_valid <= 1'b0;

      if (in_sop && state != IDLE)
        sop_err <= 1'b1;

      case (state)
        IDLE: begin
          if (in_sop) begin
            rw_en   <= act.rewrite_en;
            rw_off  <= act.rewrite_off;
            rw_val  <= act.rewrite_val;
            idx     <= 11'd0;
            tx_port <= act.port;
            state   <= act.drop ? DROP : FWD;
          end
        end
        FWD: begin
          if (accept) begin
            tx_data  <= rw_hit ? rw_val : in_data;
            tx_last  <= in_last;
            tx_valid <= 1'b1;
            if (idx != 11'h7FF)
              idx <= idx + 11'd1;
            if (in_last) begin
              state <= IDLE;
              if (pkt_fwd_cnt != '1)
                pkt_fwd_cnt <= pkt_fwd_cnt + 1'b1;
            end
          end
        end
        DROP: begin
          if (accept) begin
            if (idx != 11'h7FF)
              idx <= idx + 11'd1;
            if (in_last) begin
              state <= IDLE;
              if (pkt_drop_cnt != '1)
                pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_egress_executor.sv
// Directed bench: a table of packet actions plus hand sequences for backpressure, sop errors, saturation and reset.
module tb_packet_egress_executor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_sop;
  logic [63:0] in_action;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic [1:0]  tx_port;
  logic        tx_ready;
  logic [15:0] pkt_fwd_cnt;
  logic [15:0] pkt_drop_cnt;
  logic        sop_err;

  // Second instance with 2-bit counters shares all inputs to exercise saturation.
  logic        unused_s_in_ready, unused_s_tx_valid, unused_s_tx_last, unused_s_sop_err;
  logic [7:0]  unused_s_tx_data;
  logic [1:0]  unused_s_tx_port;
  logic [1:0]  s_fwd_cnt, s_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  logic saw_valid = 1'b0;
  logic [10:0] mon_q[$];

  always #5 clk = ~clk;

  packet_egress_executor dut (
    .clk(clk), .rst_n(rst_n), .in_sop(in_sop), .in_action(in_action),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_port(tx_port),
    .tx_ready(tx_ready), .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt),
    .sop_err(sop_err)
  );

  packet_egress_executor #(.ACTION_W(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_sop(in_sop), .in_action(in_action),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(unused_s_in_ready),
    .tx_valid(unused_s_tx_valid), .tx_data(unused_s_tx_data), .tx_last(unused_s_tx_last),
    .tx_port(unused_s_tx_port), .tx_ready(tx_ready), .pkt_fwd_cnt(s_fwd_cnt),
    .pkt_drop_cnt(s_drop_cnt), .sop_err(unused_s_sop_err)
  );

  always @(negedge clk) begin
    if (tx_valid)
      saw_valid = 1'b1;
    if (rst_n && tx_valid && tx_ready)
      mon_q.push_back({tx_port, tx_last, tx_data});
  end

  typedef struct {
    logic [63:0]      action;
    int               len;
    logic [15:0][7:0] din;
    logic [15:0][7:0] dexp;
    logic             drop;
    logic [1:0]       port;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_fwd_cnt"}, pkt_fwd_cnt, exp_fwd);
    check({tag, "_drop_cnt"}, pkt_drop_cnt, exp_drop);
    check({tag, "_sat_fwd"}, s_fwd_cnt, sat3(exp_fwd));
    check({tag, "_sat_drop"}, s_drop_cnt, sat3(exp_drop));
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_sop(input logic [63:0] act);
    in_sop = 1'b1;
    in_action = act;
    tick();
    in_sop = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic last, output int waits);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_accept_timeout: in_ready stayed 0 for %0d cycles", waits);
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_pkt(input logic [63:0] act, input int len, input logic [15:0][7:0] din,
                         input logic [15:0][7:0] dexp, input logic drop, input logic [1:0] port);
    int w;
    logic [10:0] e;
    mon_q.delete();
    send_sop(act);
    saw_valid = 1'b0;
    check("port_on_sop", tx_port, port);
    for (int i = 0; i < len; i++) begin
      drive_byte(din[i], (i == len - 1), w);
      if (drop) check("drop_in_ready", w, 0);
    end
    check("idle_in_ready", in_ready, 0);
    if (drop) exp_drop++; else exp_fwd++;
    check_counts("pkt");
    repeat (2) tick();
    check("tx_beats", mon_q.size(), drop ? 0 : len);
    if (drop)
      check("drop_no_valid", saw_valid, 0);
    else
      for (int i = 0; i < len && i < mon_q.size(); i++) begin
        e = mon_q[i];
        check("tx_data", e[7:0], dexp[i]);
        check("tx_last", e[8], (i == len - 1));
        check("tx_port", e[10:9], port);
      end
  endtask

  initial begin
    int w;
    logic [7:0] exp3[3];

    rst_n = 1'b0; in_sop = 1'b0; in_action = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; tx_ready = 1'b1;

    vecs[0] = '{64'h8, 4, 128'h44332211, 128'h44332211, 1'b0, 2'd2};
    vecs[1] = '{64'h00AB0202, 5, 128'h0403020100, 128'h0403AB0100, 1'b0, 2'd0};
    vecs[2] = '{64'h00AB0902, 5, 128'h0403020100, 128'h0403020100, 1'b0, 2'd0};
    vecs[3] = '{64'h0D, 6, 128'h665544332211, 128'h0, 1'b1, 2'd3};
    vecs[4] = '{64'hFFFF_FFFF_FF00_00F6, 2, 128'h5B5A, 128'h5B00, 1'b0, 2'd1};
    vecs[5] = '{64'h0077000E, 1, 128'h99, 128'h77, 1'b0, 2'd3};
    vecs[6] = '{64'h1, 1, 128'hEE, 128'h0, 1'b1, 2'd0};
    vecs[7] = '{64'h1, 1, 128'hEE, 128'h0, 1'b1, 2'd0};
    vecs[8] = '{64'h1, 1, 128'hEE, 128'h0, 1'b1, 2'd0};

    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_port", tx_port, 0);
    check("rst_sop_err", sop_err, 0);
    check_counts("rst");
    #20 rst_n = 1'b1;
    tick();

    // Bytes offered in IDLE must not be accepted.
    in_valid = 1'b1; in_data = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_accept", in_ready, 0);
    end
    tick();
    in_valid = 1'b0;
    check("idle_no_tx", mon_q.size(), 0);

    for (int v = 0; v < 9; v++)
      run_pkt(vecs[v].action, vecs[v].len, vecs[v].din, vecs[v].dexp, vecs[v].drop, vecs[v].port);
    check("sop_err_clean", sop_err, 0);

    // Backpressure: tx_ready 1,0,0,1 during a 3-byte forward on port 1.
    mon_q.delete();
    send_sop(64'h4);
    in_valid = 1'b1; in_data = 8'hA1; in_last = 1'b0; tx_ready = 1'b1;
    @(negedge clk); check("bp_rdy0", in_ready, 1);
    tick();
    in_data = 8'hA2; tx_ready = 1'b0;
    @(negedge clk); check("bp_rdy1", in_ready, 0); check("bp_hold1", tx_data, 8'hA1);
    tick();
    @(negedge clk); check("bp_rdy2", in_ready, 0); check("bp_hold2", tx_data, 8'hA1);
    check("bp_valid2", tx_valid, 1);
    tick();
    tx_ready = 1'b1;
    @(negedge clk); check("bp_rdy3", in_ready, 1); check("bp_hold3", tx_data, 8'hA1);
    tick();
    in_data = 8'hA3; in_last = 1'b1;
    @(negedge clk); check("bp_data4", tx_data, 8'hA2);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    exp_fwd++;
    @(negedge clk); check("bp_data5", tx_data, 8'hA3); check("bp_last5", tx_last, 1);
    repeat (2) tick();
    exp3 = '{8'hA1, 8'hA2, 8'hA3};
    check("bp_beats", mon_q.size(), 3);
    for (int i = 0; i < 3 && i < mon_q.size(); i++)
      check("bp_order", mon_q[i][7:0], exp3[i]);
    check_counts("bp");

    // in_sop mid-packet is flagged and ignored; packet keeps port 3 and forwards.
    mon_q.delete();
    send_sop(64'hC);
    drive_byte(8'hC1, 1'b0, w);
    in_sop = 1'b1; in_action = 64'h1;
    drive_byte(8'hC2, 1'b0, w);
    in_sop = 1'b0;
    check("sop_err_set", sop_err, 1);
    drive_byte(8'hC3, 1'b1, w);
    exp_fwd++;
    repeat (2) tick();
    exp3 = '{8'hC1, 8'hC2, 8'hC3};
    check("sopmid_beats", mon_q.size(), 3);
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      check("sopmid_data", mon_q[i][7:0], exp3[i]);
      check("sopmid_port", mon_q[i][10:9], 3);
    end
    check_counts("sopmid");
    check("sop_err_sticky", sop_err, 1);

    // Reset during byte 3 of an 8-byte forward.
    send_sop(64'h8);
    drive_byte(8'h10, 1'b0, w);
    drive_byte(8'h11, 1'b0, w);
    in_valid = 1'b1; in_data = 8'h12;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 0);
    check("mrst_tx_valid", tx_valid, 0);
    check("mrst_tx_data", tx_data, 0);
    check("mrst_tx_last", tx_last, 0);
    check("mrst_tx_port", tx_port, 0);
    check("mrst_sop_err", sop_err, 0);
    exp_fwd = 0; exp_drop = 0;
    check_counts("mrst");
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_pkt(64'h8, 4, 128'h44332211, 128'h44332211, 1'b0, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
